// File: rtl/dataio_responder_if.sv
// Core data IO port and memory bus bundle for dataio_responder.
// slave = responder side, master = core/memory models driving it.
interface dataio_responder_if;
   logic        iCORE_REQ;
   logic        oCORE_BUSY;
   logic [1:0]  iCORE_ORDER;
   logic [3:0]  iCORE_MASK;
   logic        iCORE_RW;
   logic [13:0] iCORE_TID;
   logic [1:0]  iCORE_MMUMOD;
   logic [31:0] iCORE_PDT;
   logic [31:0] iCORE_ADDR;
   logic [31:0] iCORE_DATA;
   logic        oCORE_REQ;
   logic [31:0] oCORE_DATA;
   logic        oMEM_REQ;
   logic        iMEM_ACK;
   logic        oMEM_RW;
   logic [31:0] oMEM_ADDR;
   logic [3:0]  oMEM_BE;
   logic [31:0] oMEM_DATA;
   logic [13:0] oMEM_TID;
   logic [1:0]  oMEM_MMUMOD;
   logic [31:0] oMEM_PDT;
   logic        iMEM_VALID;
   logic [31:0] iMEM_DATA;
   logic        oMISALIGN_VALID;
   logic [31:0] oMISALIGN_ADDR;

   modport slave (
      input  iCORE_REQ, iCORE_ORDER, iCORE_MASK, iCORE_RW, iCORE_TID, iCORE_MMUMOD,
             iCORE_PDT, iCORE_ADDR, iCORE_DATA, iMEM_ACK, iMEM_VALID, iMEM_DATA,
      output oCORE_BUSY, oCORE_REQ, oCORE_DATA, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BE,
             oMEM_DATA, oMEM_TID, oMEM_MMUMOD, oMEM_PDT, oMISALIGN_VALID, oMISALIGN_ADDR
   );

   modport master (
      output iCORE_REQ, iCORE_ORDER, iCORE_MASK, iCORE_RW, iCORE_TID, iCORE_MMUMOD,
             iCORE_PDT, iCORE_ADDR, iCORE_DATA, iMEM_ACK, iMEM_VALID, iMEM_DATA,
      input  oCORE_BUSY, oCORE_REQ, oCORE_DATA, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BE,
             oMEM_DATA, oMEM_TID, oMEM_MMUMOD, oMEM_PDT, oMISALIGN_VALID, oMISALIGN_ADDR
   );
endinterface

// File: rtl/dataio_responder.sv
// Memory-side responder for the core data IO port: in-order request FIFO to a byte-enable bus.
// Optional misalignment trap enabled by defining DATAIO_RESPONDER_MISALIGN_CHECK_EN.
module dataio_responder #(
   parameter int P_DEPTH   = 4,
   parameter int P_DEPTH_N = 2
)(
   input  logic              iCLOCK,
   input  logic              iRESET_SYNC,
   dataio_responder_if.slave bus
);
   typedef struct packed {
      logic        rw;
      logic        none;
      logic [13:0] tid;
      logic [1:0]  mmumod;
      logic [31:0] pdt;
      logic [29:0] waddr;
      logic [3:0]  be;
      logic [31:0] data;
   } entry_t;

   localparam logic [P_DEPTH_N:0]   LP_FULL    = (P_DEPTH_N+1)'(P_DEPTH);
   localparam logic [P_DEPTH_N:0]   LP_CNT_ONE = (P_DEPTH_N+1)'(1);
   localparam logic [P_DEPTH_N-1:0] LP_PTR_ONE = P_DEPTH_N'(1);

   entry_t               r_fifo [P_DEPTH];
   logic [P_DEPTH_N-1:0] r_wptr, r_rptr;
   logic [P_DEPTH_N:0]   r_count;
   logic                 r_load_pending, r_guard, r_core_req;
   logic [31:0]          r_core_data;

   entry_t w_new, w_head;
   logic   w_busy, w_accept, w_empty, w_mem_req, w_pop, w_misalign, w_unused;

   // Guard masks the stale request still held on the port right after a load response.
   assign w_busy    = (r_count == LP_FULL) || r_load_pending;
   assign w_accept  = bus.iCORE_REQ && !w_busy && !r_guard;
   assign w_empty   = (r_count == '0);
   assign w_head    = r_fifo[r_rptr];
   assign w_mem_req = !w_empty && !w_head.none;
   assign w_pop     = !w_empty && (w_head.none || bus.iMEM_ACK);
   assign w_unused  = ^bus.iCORE_MASK;

`ifdef DATAIO_RESPONDER_MISALIGN_CHECK_EN
   logic        r_mis_valid;
   logic [31:0] r_mis_addr;

   assign w_misalign = (bus.iCORE_ORDER == 2'b01 && bus.iCORE_ADDR[0]) ||
                       (bus.iCORE_ORDER == 2'b10 && bus.iCORE_ADDR[1:0] != 2'b00);

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         r_mis_valid <= 1'b0;
         r_mis_addr  <= '0;
      end else begin
         r_mis_valid <= w_accept && w_misalign;
         if (w_accept && w_misalign) r_mis_addr <= bus.iCORE_ADDR;
      end
   end

   assign bus.oMISALIGN_VALID = r_mis_valid;
   assign bus.oMISALIGN_ADDR  = r_mis_addr;
`else
   assign w_misalign          = 1'b0;
   assign bus.oMISALIGN_VALID = 1'b0;
   assign bus.oMISALIGN_ADDR  = '0;
`endif

   always_comb begin
      w_new        = '0;
      w_new.rw     = bus.iCORE_RW;
      w_new.tid    = bus.iCORE_TID;
      w_new.mmumod = bus.iCORE_MMUMOD;
      w_new.pdt    = bus.iCORE_PDT;
      w_new.waddr  = bus.iCORE_ADDR[31:2];
      case (bus.iCORE_ORDER)
         2'b00: begin
            w_new.be   = 4'b0001 << bus.iCORE_ADDR[1:0];
            w_new.data = {24'h0, bus.iCORE_DATA[7:0]} << {bus.iCORE_ADDR[1:0], 3'b000};
         end
         2'b01: begin
            w_new.be   = bus.iCORE_ADDR[1] ? 4'b1100 : 4'b0011;
            w_new.data = bus.iCORE_ADDR[1] ? {bus.iCORE_DATA[15:0], 16'h0}
                                           : {16'h0, bus.iCORE_DATA[15:0]};
         end
         2'b10: begin
            w_new.be   = 4'b1111;
            w_new.data = bus.iCORE_DATA;
         end
         default: w_new.none = 1'b1;
      endcase
      if (w_misalign) begin
         w_new.none = 1'b1;
         w_new.be   = '0;
         w_new.data = '0;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (w_accept) r_fifo[r_wptr] <= w_new;
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_load_pending <= 1'b0;
         r_guard        <= 1'b0;
         r_core_req     <= 1'b0;
         r_core_data    <= '0;
      end else begin
         if (w_accept) r_wptr <= r_wptr + LP_PTR_ONE;
         if (w_pop)    r_rptr <= r_rptr + LP_PTR_ONE;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
         r_guard    <= r_core_req;
         r_core_req <= 1'b0;
         // Only one load can be outstanding, so any valid while pending belongs to it.
         if (r_load_pending && !r_core_req && bus.iMEM_VALID) begin
            r_core_req  <= 1'b1;
            r_core_data <= bus.iMEM_DATA;
         end else if (w_pop && w_head.none && !w_head.rw) begin
            r_core_req  <= 1'b1;
            r_core_data <= '0;
         end
         if (r_core_req)                   r_load_pending <= 1'b0;
         else if (w_accept && !bus.iCORE_RW) r_load_pending <= 1'b1;
      end
   end

   assign bus.oCORE_BUSY  = w_busy;
   assign bus.oCORE_REQ   = r_core_req;
   assign bus.oCORE_DATA  = r_core_data;
   assign bus.oMEM_REQ    = w_mem_req;
   assign bus.oMEM_RW     = w_mem_req && w_head.rw;
   assign bus.oMEM_ADDR   = w_mem_req ? {w_head.waddr, 2'b00} : '0;
   assign bus.oMEM_BE     = w_mem_req ? w_head.be     : '0;
   assign bus.oMEM_DATA   = w_mem_req ? w_head.data   : '0;
   assign bus.oMEM_TID    = w_mem_req ? w_head.tid    : '0;
   assign bus.oMEM_MMUMOD = w_mem_req ? w_head.mmumod : '0;
   assign bus.oMEM_PDT    = w_mem_req ? w_head.pdt    : '0;
endmodule
